// File: rtl/spi_frame_dispatch_pkg.sv
// Shared constants and types for the SPI frame dispatcher.
// Field offsets are measured in bits from the MSB of the frame.
package spi_dispatch_pkg;

  localparam int HDR_W       = 64;
  localparam int WORD_W      = 32;
  localparam int MSGID_OFS   = 0;
  localparam int SEQ_OFS     = 32;
  localparam int OUTBITS_OFS = 40;
  localparam int RSVD_OFS    = 48;
  localparam int SP_OFS      = HDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_frame_dispatch_if.sv
// Bus bundle between the SPI slave side / application and the frame dispatcher.
interface spi_frame_dispatch_if #(
  parameter int NUM_SP      = 3,
  parameter int BUFFER_SIZE = 64 + 32*NUM_SP
) ();

  logic [BUFFER_SIZE-1:0] rx_data;
  logic                   pkg_timeout;
  logic [NUM_SP*32-1:0]   fb_data;
  logic [15:0]            in_bits;
  logic [BUFFER_SIZE-1:0] tx_data;
  logic [NUM_SP*32-1:0]   setpoint;
  logic [7:0]             out_bits;
  logic                   frame_strobe;
  logic                   link_ok;
  logic [15:0]            seq_err_cnt;

  modport master (
    output rx_data, pkg_timeout, fb_data, in_bits,
    input  tx_data, setpoint, out_bits, frame_strobe, link_ok, seq_err_cnt
  );

  modport slave (
    input  rx_data, pkg_timeout, fb_data, in_bits,
    output tx_data, setpoint, out_bits, frame_strobe, link_ok, seq_err_cnt
  );

endinterface

// File: rtl/spi_tx_packer.sv
// Registered reply-frame assembly: header, sequence echo, link flag, inputs, feedback words.
module spi_tx_packer
  import spi_dispatch_pkg::*;
#(
  parameter int          NUM_SP      = 3,
  parameter int          BUFFER_SIZE = 64 + 32*NUM_SP,
  parameter logic [31:0] MSGID_TX    = 32'h64617461
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             last_seq_i,
  input  logic                   link_ok_i,
  input  logic [15:0]            in_bits_i,
  input  logic [NUM_SP*32-1:0]   fb_data_i,
  output logic [BUFFER_SIZE-1:0] tx_data_o
);

  logic [BUFFER_SIZE-1:0] tx_q, tx_d;

  always_comb begin
    tx_d = '0;
    tx_d[BUFFER_SIZE-1-MSGID_OFS -: 32]   = MSGID_TX;
    tx_d[BUFFER_SIZE-1-SEQ_OFS -: 8]      = last_seq_i;
    tx_d[BUFFER_SIZE-1-OUTBITS_OFS -: 8]  = {link_ok_i, 7'b0};
    tx_d[BUFFER_SIZE-1-RSVD_OFS -: 16]    = in_bits_i;
    // Feedback word 0 sits directly after the header, mirroring the rx layout.
    for (int i = 0; i < NUM_SP; i++) begin
      tx_d[BUFFER_SIZE-1-SP_OFS-WORD_W*i -: WORD_W] = fb_data_i[WORD_W*i +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= '0;
    else        tx_q <= tx_d;
  end

  assign tx_data_o = tx_q;

endmodule

// File: rtl/spi_frame_dispatch.sv
// Frame dispatcher: detects new SPI frames by SEQ, unpacks setpoints one word per cycle, commits atomically.
// Define SPI_DISPATCH_SEQCHK_EN to build the sequence-gap counter; otherwise seq_err_cnt is tied to 0.
module spi_frame_dispatch
  import spi_dispatch_pkg::*;
#(
  parameter int          NUM_SP      = 3,
  parameter int          BUFFER_SIZE = 64 + 32*NUM_SP,
  parameter logic [31:0] MSGID_TX    = 32'h64617461
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_frame_dispatch_if.slave bus
);

  localparam int              IDX_W    = (NUM_SP > 1) ? $clog2(NUM_SP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SP-1);

  state_e                       state_q, state_d;
  logic [BUFFER_SIZE-1:0]       shadow_q, shadow_d;
  logic [NUM_SP-1:0][WORD_W-1:0] staging_q, staging_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_SP*32-1:0]         setpoint_q, setpoint_d;
  logic [7:0]                   out_bits_q, out_bits_d;
  logic [7:0]                   last_seq_q, last_seq_d;
  logic                         strobe_q, strobe_d;
  logic                         link_ok_q, link_ok_d;
  logic                         has_frame_q, has_frame_d;

  logic [7:0]        rx_seq, shadow_seq, shadow_outbits;
  logic [WORD_W-1:0] unpack_word;
  logic              unused_fields;

  assign rx_seq         = bus.rx_data[BUFFER_SIZE-1-SEQ_OFS -: 8];
  assign shadow_seq     = shadow_q[BUFFER_SIZE-1-SEQ_OFS -: 8];
  assign shadow_outbits = shadow_q[BUFFER_SIZE-1-OUTBITS_OFS -: 8];
  assign unused_fields  = ^{shadow_q[BUFFER_SIZE-1-MSGID_OFS -: 32],
                            shadow_q[BUFFER_SIZE-1-RSVD_OFS -: 16]};

  always_comb begin
    unpack_word = '0;
    for (int i = 0; i < NUM_SP; i++) begin
      if (idx_q == IDX_W'(i)) unpack_word = shadow_q[BUFFER_SIZE-1-SP_OFS-WORD_W*i -: WORD_W];
    end
  end

  // Timeout overrides every state, including COMMIT, so a stale frame can never land.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    staging_d   = staging_q;
    idx_d       = idx_q;
    setpoint_d  = setpoint_q;
    out_bits_d  = out_bits_q;
    last_seq_d  = last_seq_q;
    strobe_d    = 1'b0;
    link_ok_d   = link_ok_q;
    has_frame_d = has_frame_q;
    if (bus.pkg_timeout) begin
      state_d    = IDLE;
      idx_d      = '0;
      setpoint_d = '0;
      out_bits_d = '0;
      link_ok_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_seq != last_seq_q) begin
            shadow_d = bus.rx_data;
            idx_d    = '0;
            state_d  = UNPACK;
          end
        end
        UNPACK: begin
          for (int i = 0; i < NUM_SP; i++) begin
            if (idx_q == IDX_W'(i)) staging_d[i] = unpack_word;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = COMMIT;
        end
        COMMIT: begin
          setpoint_d  = staging_q;
          out_bits_d  = shadow_outbits;
          last_seq_d  = shadow_seq;
          strobe_d    = 1'b1;
          link_ok_d   = 1'b1;
          has_frame_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      staging_q   <= '0;
      idx_q       <= '0;
      setpoint_q  <= '0;
      out_bits_q  <= '0;
      last_seq_q  <= 8'h00;
      strobe_q    <= 1'b0;
      link_ok_q   <= 1'b0;
      has_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      staging_q   <= staging_d;
      idx_q       <= idx_d;
      setpoint_q  <= setpoint_d;
      out_bits_q  <= out_bits_d;
      last_seq_q  <= last_seq_d;
      strobe_q    <= strobe_d;
      link_ok_q   <= link_ok_d;
      has_frame_q <= has_frame_d;
    end
  end

`ifdef SPI_DISPATCH_SEQCHK_EN
  logic [15:0] seq_err_q, seq_err_d;

  // A gap is only meaningful once there is a previous committed SEQ to compare against.
  always_comb begin
    seq_err_d = seq_err_q;
    if (strobe_d && has_frame_q && (shadow_seq != last_seq_q + 8'd1) && (seq_err_q != 16'hFFFF))
      seq_err_d = seq_err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_err_q <= '0;
    else        seq_err_q <= seq_err_d;
  end

  assign bus.seq_err_cnt = seq_err_q;
`else
  assign bus.seq_err_cnt = '0;
`endif

  assign bus.setpoint     = setpoint_q;
  assign bus.out_bits     = out_bits_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.link_ok      = link_ok_q;

  spi_tx_packer #(
    .NUM_SP      (NUM_SP),
    .BUFFER_SIZE (BUFFER_SIZE),
    .MSGID_TX    (MSGID_TX)
  ) u_tx_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .last_seq_i (last_seq_q),
    .link_ok_i  (link_ok_q),
    .in_bits_i  (bus.in_bits),
    .fb_data_i  (bus.fb_data),
    .tx_data_o  (bus.tx_data)
  );

endmodule

// File: tb/tb_spi_frame_dispatch.sv
// Directed bench for spi_frame_dispatch with hand-computed expectations (NUM_SP=3, BUFFER_SIZE=160).
module tb_spi_frame_dispatch;

  localparam int          NumSp   = 3;
  localparam int          BufSize = 160;
  localparam logic [31:0] MsgIdTx = 32'h64617461;

`ifdef SPI_DISPATCH_SEQCHK_EN
  localparam logic [15:0] GapErrs = 16'd1;
`else
  localparam logic [15:0] GapErrs = 16'd0;
`endif

  localparam logic [95:0] FbWords = {32'h0BADBEEF, 32'hCAFEF00D, 32'h12345678};

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  spi_frame_dispatch_if #(.NUM_SP(NumSp), .BUFFER_SIZE(BufSize)) bus ();

  spi_frame_dispatch #(
    .NUM_SP      (NumSp),
    .BUFFER_SIZE (BufSize),
    .MSGID_TX    (MsgIdTx)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [159:0] makeFrame(input logic [7:0] seq, input logic [7:0] outBits,
                                             input logic [31:0] sp0, input logic [31:0] sp1,
                                             input logic [31:0] sp2);
    return {32'hA5A50001, seq, outBits, 16'h0000, sp0, sp1, sp2};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitStrobe(input int maxCycles, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < maxCycles) begin
      stepCycle();
      cycles++;
      if (bus.frame_strobe === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.rx_data     = '0;
    bus.pkg_timeout = 1'b0;
    bus.fb_data     = '0;
    bus.in_bits     = '0;
    repeat (3) stepCycle();
    checks++; if (bus.setpoint !== 96'h0) begin errors++; $display("[TB] FAIL reset_setpoint got %h want 0", bus.setpoint); end
    checks++; if (bus.out_bits !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_bits got %h want 00", bus.out_bits); end
    checks++; if (bus.frame_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got %b want 0", bus.frame_strobe); end
    checks++; if (bus.link_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_link_ok got %b want 0", bus.link_ok); end
    checks++; if (bus.seq_err_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_seq_err got %h want 0", bus.seq_err_cnt); end
    checks++; if (bus.tx_data !== 160'h0) begin errors++; $display("[TB] FAIL reset_tx_data got %h want 0", bus.tx_data); end
    rst_n = 1'b1;
    stepCycle();
    checks++;
    if (bus.tx_data !== {MsgIdTx, 8'h00, 8'h00, 16'h0000, 96'h0}) begin
      errors++; $display("[TB] FAIL idle_tx_header got %h want %h", bus.tx_data, {MsgIdTx, 128'h0});
    end
  endtask

  task automatic test_first_frame();
    logic [95:0] expSp;
    expSp = {32'h00000007, 32'hFFFFFFF0, 32'h00000010};
    bus.rx_data = makeFrame(8'd1, 8'hA5, 32'h00000010, 32'hFFFFFFF0, 32'h00000007);
    // Cycle 1 is the detection edge; the strobe lands NUM_SP+1 edges later.
    for (int k = 1; k <= 5; k++) begin
      stepCycle();
      checks++;
      if (bus.frame_strobe !== (k == 5)) begin
        errors++; $display("[TB] FAIL frame_strobe_cycle%0d got %b want %b", k, bus.frame_strobe, (k == 5));
      end
      if (k < 5) begin
        checks++;
        if (bus.setpoint !== 96'h0) begin
          errors++; $display("[TB] FAIL setpoint_stable_cycle%0d got %h want 0", k, bus.setpoint);
        end
      end
    end
    checks++; if (bus.setpoint !== expSp) begin errors++; $display("[TB] FAIL frame1_setpoint got %h want %h", bus.setpoint, expSp); end
    checks++; if (bus.out_bits !== 8'hA5) begin errors++; $display("[TB] FAIL frame1_out_bits got %h want a5", bus.out_bits); end
    checks++; if (bus.link_ok !== 1'b1) begin errors++; $display("[TB] FAIL frame1_link_ok got %b want 1", bus.link_ok); end
    checks++; if (bus.seq_err_cnt !== 16'h0) begin errors++; $display("[TB] FAIL frame1_seq_err got %h want 0", bus.seq_err_cnt); end
    stepCycle();
    checks++; if (bus.frame_strobe !== 1'b0) begin errors++; $display("[TB] FAIL strobe_one_cycle got %b want 0", bus.frame_strobe); end
  endtask

  task automatic test_same_seq();
    int strobes;
    strobes = 0;
    bus.rx_data = makeFrame(8'd1, 8'h5A, 32'h11111111, 32'h22222222, 32'h33333333);
    repeat (10) begin
      stepCycle();
      if (bus.frame_strobe === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL same_seq_strobes got %0d want 0", strobes); end
    checks++;
    if (bus.setpoint !== {32'h00000007, 32'hFFFFFFF0, 32'h00000010}) begin
      errors++; $display("[TB] FAIL same_seq_setpoint got %h want unchanged", bus.setpoint);
    end
    checks++; if (bus.out_bits !== 8'hA5) begin errors++; $display("[TB] FAIL same_seq_out_bits got %h want a5", bus.out_bits); end
  endtask

  task automatic test_seq_gap();
    int cycles;
    bit seen;
    bus.rx_data = makeFrame(8'd3, 8'h3C, 32'h00000001, 32'h00000002, 32'h00000003);
    waitStrobe(12, cycles, seen);
    checks++;
    if (!seen || cycles != 5) begin
      errors++; $display("[TB] FAIL gap_latency got seen=%0b cycles=%0d want seen=1 cycles=5", seen, cycles);
    end
    checks++;
    if (bus.setpoint !== {32'h00000003, 32'h00000002, 32'h00000001}) begin
      errors++; $display("[TB] FAIL gap_setpoint got %h want 000000030000000200000001", bus.setpoint);
    end
    checks++; if (bus.out_bits !== 8'h3C) begin errors++; $display("[TB] FAIL gap_out_bits got %h want 3c", bus.out_bits); end
    checks++; if (bus.seq_err_cnt !== GapErrs) begin errors++; $display("[TB] FAIL gap_seq_err got %h want %h", bus.seq_err_cnt, GapErrs); end
  endtask

  task automatic test_tx_packer();
    logic [159:0] expTx;
    bus.fb_data = FbWords;
    bus.in_bits = 16'hBEEF;
    repeat (2) stepCycle();
    expTx = {MsgIdTx, 8'd3, 8'h80, 16'hBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF};
    checks++; if (bus.tx_data !== expTx) begin errors++; $display("[TB] FAIL tx_link_up got %h want %h", bus.tx_data, expTx); end
  endtask

  task automatic test_timeout();
    int strobes;
    int cycles;
    bit seen;
    logic [159:0] expTx;
    strobes = 0;
    bus.rx_data = makeFrame(8'd4, 8'h0F, 32'h0000000A, 32'h0000000B, 32'h0000000C);
    repeat (2) stepCycle();
    bus.pkg_timeout = 1'b1;
    stepCycle();
    if (bus.frame_strobe === 1'b1) strobes++;
    checks++; if (bus.setpoint !== 96'h0) begin errors++; $display("[TB] FAIL timeout_setpoint got %h want 0", bus.setpoint); end
    checks++; if (bus.out_bits !== 8'h00) begin errors++; $display("[TB] FAIL timeout_out_bits got %h want 00", bus.out_bits); end
    checks++; if (bus.link_ok !== 1'b0) begin errors++; $display("[TB] FAIL timeout_link_ok got %b want 0", bus.link_ok); end
    repeat (5) begin
      stepCycle();
      if (bus.frame_strobe === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL timeout_strobes got %0d want 0", strobes); end
    expTx = {MsgIdTx, 8'd3, 8'h00, 16'hBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF};
    checks++; if (bus.tx_data !== expTx) begin errors++; $display("[TB] FAIL tx_link_down got %h want %h", bus.tx_data, expTx); end
    bus.pkg_timeout = 1'b0;
    waitStrobe(12, cycles, seen);
    checks++;
    if (!seen || cycles != 5) begin
      errors++; $display("[TB] FAIL recover_latency got seen=%0b cycles=%0d want seen=1 cycles=5", seen, cycles);
    end
    checks++;
    if (bus.setpoint !== {32'h0000000C, 32'h0000000B, 32'h0000000A}) begin
      errors++; $display("[TB] FAIL recover_setpoint got %h want 0000000c0000000b0000000a", bus.setpoint);
    end
    checks++; if (bus.out_bits !== 8'h0F) begin errors++; $display("[TB] FAIL recover_out_bits got %h want 0f", bus.out_bits); end
    checks++; if (bus.link_ok !== 1'b1) begin errors++; $display("[TB] FAIL recover_link_ok got %b want 1", bus.link_ok); end
    checks++; if (bus.seq_err_cnt !== GapErrs) begin errors++; $display("[TB] FAIL recover_seq_err got %h want %h", bus.seq_err_cnt, GapErrs); end
  endtask

  task automatic test_reset_mid_unpack();
    int strobes;
    int cycles;
    bit seen;
    strobes = 0;
    bus.rx_data = makeFrame(8'd9, 8'hEE, 32'h99999999, 32'h88888888, 32'h77777777);
    repeat (2) stepCycle();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.setpoint !== 96'h0) begin errors++; $display("[TB] FAIL rst_mid_setpoint got %h want 0", bus.setpoint); end
    checks++; if (bus.out_bits !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_out_bits got %h want 00", bus.out_bits); end
    checks++; if (bus.link_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_link_ok got %b want 0", bus.link_ok); end
    checks++; if (bus.tx_data !== 160'h0) begin errors++; $display("[TB] FAIL rst_mid_tx_data got %h want 0", bus.tx_data); end
    bus.rx_data = '0;
    repeat (2) stepCycle();
    rst_n = 1'b1;
    repeat (8) begin
      stepCycle();
      if (bus.frame_strobe === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL rst_mid_strobes got %0d want 0", strobes); end
    checks++; if (bus.setpoint !== 96'h0) begin errors++; $display("[TB] FAIL rst_hold_setpoint got %h want 0", bus.setpoint); end
    bus.rx_data = makeFrame(8'd5, 8'h81, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    waitStrobe(12, cycles, seen);
    checks++;
    if (!seen || cycles != 5) begin
      errors++; $display("[TB] FAIL post_rst_latency got seen=%0b cycles=%0d want seen=1 cycles=5", seen, cycles);
    end
    checks++;
    if (bus.setpoint !== {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001}) begin
      errors++; $display("[TB] FAIL post_rst_setpoint got %h want dead0003dead0002dead0001", bus.setpoint);
    end
    checks++; if (bus.out_bits !== 8'h81) begin errors++; $display("[TB] FAIL post_rst_out_bits got %h want 81", bus.out_bits); end
    checks++; if (bus.seq_err_cnt !== 16'h0) begin errors++; $display("[TB] FAIL post_rst_seq_err got %h want 0", bus.seq_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_same_seq();
    test_seq_gap();
    test_tx_packer();
    test_timeout();
    test_reset_mid_unpack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
